// File: rtl/accum_count_reg.sv
// Step-driven accumulator: after start, sums addends over CNT_MAX accepted steps,
// tracks a sticky overflow carry and pulses done for one cycle on completion.
module accum_count_reg #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned CNT_WIDTH = 4,
  parameter int unsigned CNT_MAX   = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 step,
  input  logic                 add_en,
  input  logic [WIDTH-1:0]     addend,
  output logic [WIDTH-1:0]     sum,
  output logic [CNT_WIDTH-1:0] count,
  output logic                 carry,
  output logic                 busy,
  output logic                 done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(CNT_MAX - 1);

  state_t               state;
  state_t               state_nxt;
  logic [WIDTH-1:0]     sum_nxt;
  logic [CNT_WIDTH-1:0] count_nxt;
  logic                 carry_nxt;
  logic [WIDTH:0]       add_full;

  // Extra bit captures the carry-out of each addition.
  assign add_full = {1'b0, sum} + {1'b0, addend};

  // State and datapath registers; busy/done are registered decodes of the next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      sum   <= '0;
      count <= '0;
      carry <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      sum   <= sum_nxt;
      count <= count_nxt;
      carry <= carry_nxt;
      busy  <= (state_nxt == S_RUN);
      done  <= (state_nxt == S_DONE);
    end
  end

  // Next-state and datapath update; everything holds unless a transition says otherwise.
  always_comb begin
    state_nxt = state;
    sum_nxt   = sum;
    count_nxt = count;
    carry_nxt = carry;
    case (state)
      S_IDLE: begin
        if (start) begin
          sum_nxt   = '0;
          count_nxt = '0;
          carry_nxt = 1'b0;
          state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (step) begin
          count_nxt = count + CNT_WIDTH'(1);
          if (add_en) begin
            sum_nxt   = add_full[WIDTH-1:0];
            carry_nxt = carry | add_full[WIDTH];
          end
          if (count == CNT_LAST) begin
            state_nxt = S_DONE;
          end
        end
      end
      S_DONE: begin
        // Start here chains straight into a new run without passing through IDLE.
        if (start) begin
          sum_nxt   = '0;
          count_nxt = '0;
          carry_nxt = 1'b0;
          state_nxt = S_RUN;
        end else begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: doc/accum_count_reg.md
ACCUM_COUNT_REG -- requirements
Module: accum_count_reg

Interface
REQ-001 SHALL have parameter WIDTH, default 8, accumulated-sum width in bits.
REQ-002 SHALL have parameter CNT_WIDTH, default 4, iteration-counter width in bits.
REQ-003 SHALL have parameter CNT_MAX, default 4, number of accepted steps per operation.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port start  input  1  begin operation: clears sum, count and carry.
REQ-007 SHALL have port step  input  1  advance one iteration when in RUN.
REQ-008 SHALL have port add_en  input  1  on an accepted step, add addend to sum; else sum holds.
REQ-009 SHALL have port addend  input  WIDTH  value added on an accepted step with add_en high.
REQ-010 SHALL have port sum  output  WIDTH  registered accumulated sum.
REQ-011 SHALL have port count  output  CNT_WIDTH  registered count of accepted steps.
REQ-012 SHALL have port carry  output  1  sticky flag: any addition overflowed WIDTH bits.
REQ-013 SHALL have port busy  output  1  high while in RUN.
REQ-014 SHALL have port done  output  1  one-cycle pulse when the operation completes.

Function
REQ-015 SHALL implement three states: IDLE, RUN, DONE; busy = (RUN), done = (DONE), both registered-state decodes.
REQ-016 SHALL in IDLE: on start, load sum=0, count=0, carry=0 and go to RUN; otherwise hold all registers.
REQ-017 SHALL in RUN: accept a step in each cycle with step high; on a cycle with step low, hold sum, count and carry.
REQ-018 SHALL on an accepted step: count <= count+1; if add_en, sum <= (sum+addend) mod 2^WIDTH and carry <= carry | carry-out.
REQ-019 SHALL transition RUN->DONE on the accepted step taking count from CNT_MAX-1 to CNT_MAX.
REQ-020 SHALL ignore start while in RUN: no clear, no restart.
REQ-021 SHALL remain in DONE for exactly one cycle: with start high, clear and go to RUN; otherwise go to IDLE.
REQ-022 SHALL hold sum, count and carry stable from DONE until the next accepted start.
REQ-023 SHALL give, with step held high from the cycle after start, done high exactly CNT_MAX+1 cycles after the cycle in which start is sampled.
REQ-024 SHALL require CNT_MAX >= 1 and 2^CNT_WIDTH > CNT_MAX; no count wrap-around occurs in legal configurations.
REQ-025 SHALL ignore step, add_en and addend outside RUN.

Reset
REQ-026 SHALL on reset high at a clock edge force state IDLE and sum=0, count=0, carry=0, busy=0, done=0, overriding all other inputs.
REQ-027 SHALL abort an in-progress RUN or DONE on reset, with no done pulse produced.
REQ-028 SHALL accept start in the first cycle after reset deasserts.

Verification
REQ-029 SHALL pass: WIDTH=8, CNT_MAX=4; start, then 4 steps with add_en=1 and addends 3,5,7,9 -> sum=24, count=4, carry=0, done pulses once on cycle 5 after start.
REQ-030 SHALL pass: overflow; steps with addends 200,100 then two steps with add_en=0 -> sum=44, carry=1 held through DONE.
REQ-031 SHALL pass: stall; step low for 3 cycles mid-RUN -> sum/count unchanged during the stall, done delayed by exactly 3 cycles.
REQ-032 SHALL pass: start pulsed during RUN after 2 steps -> ignored; count reaches 4 and sum is not cleared.
REQ-033 SHALL pass: start high in the DONE cycle -> next cycle busy=1, sum=0, count=0, carry=0, with no IDLE cycle in between.
REQ-034 SHALL pass: reset asserted after 2 steps -> next cycle all outputs 0, state IDLE, no done pulse; a subsequent start runs normally.
